// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, with start/ready/done handshake
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             neg,
  output logic [WIDTH-1:0] mag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] mag_r;
  logic             bo_r;
  logic             done_r;

  logic             d_bit;
  logic             borrow_nx;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] d_final;
  logic [WIDTH-1:0] mag_final;

  // Full-subtractor cell; the final word includes the bit being computed this edge.
  always_comb begin
    d_bit     = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_nx = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    d_final   = {d_bit, d_sh[WIDTH-1:1]};
    mag_final = borrow_nx ? (~d_final + WIDTH'(1)) : d_final;
    last_bit  = (cnt == CW'(WIDTH - 1));
    accept    = start && (state != SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      d_r    <= '0;
      mag_r  <= '0;
      bo_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == SHIFT) && last_bit;
      if (accept) begin
        a_sh   <= A;
        b_sh   <= B;
        d_sh   <= '0;
        borrow <= 1'b0;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        d_sh   <= d_final;
        borrow <= borrow_nx;
        cnt    <= cnt + CW'(1);
        // Published outputs only move on the last bit; they hold the old result otherwise.
        if (last_bit) begin
          d_r   <= d_final;
          bo_r  <= borrow_nx;
          mag_r <= mag_final;
        end
      end
    end
  end

  assign ready = (state != SHIFT);
  assign busy  = (state == SHIFT);
  assign done  = done_r;
  assign D     = d_r;
  assign Bo    = bo_r;
  assign neg   = bo_r;
  assign mag   = mag_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic [W-1:0] mag;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bo;
  logic         neg;
  logic [W-1:0] mag;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .D(D), .Bo(Bo), .neg(neg), .mag(mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic cmp(input string name, input int act, input int req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("D", int'(D), int'(e.d));
        cmp("Bo", int'(Bo), int'(e.bo));
        cmp("neg", int'(neg), int'(e.bo));
        cmp("mag", int'(mag), int'(e.mag));
        cmp("latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!ready) cmp("ready_timeout", 0, 1);
  endtask

  // Drives start for one cycle at a negedge where ready=1; acceptance is the next posedge.
  task automatic issue(input int a, input int b, input int d, input int bo, input int m);
    exp_t e;
    wait_ready();
    start = 1'b1;
    A = W'(a);
    B = W'(b);
    e.d = W'(d);
    e.bo = bo[0];
    e.mag = W'(m);
    e.cyc = cyc + 1 + W;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    #12;
    cmp("rst_D", int'(D), 0);
    cmp("rst_Bo", int'(Bo), 0);
    cmp("rst_mag", int'(mag), 0);
    cmp("rst_ready", int'(ready), 1);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_done", int'(done), 0);
    rst_n = 1'b1;
    idle(2);

    issue(9, 3, 6, 0, 6);
    idle(6);
    issue(3, 9, 10, 1, 6);
    issue(0, 0, 0, 0, 0);
    issue(0, 15, 1, 1, 15);
    issue(15, 0, 15, 0, 15);
    issue(0, 8, 8, 1, 8);
    idle(6);

    // Start held high and operands changed during SHIFT must not disturb the 12-5 job.
    begin
      exp_t e;
      wait_ready();
      start = 1'b1;
      A = 4'd12;
      B = 4'd5;
      e.d = 4'd7; e.bo = 1'b0; e.mag = 4'd7; e.cyc = cyc + 1 + W;
      exp_q.push_back(e);
      @(negedge clk);
      A = 4'd7;
      B = 4'd7;
      cmp("busy_in_shift", int'(busy), 1);
      cmp("ready_in_shift", int'(ready), 0);
      idle(2);
      start = 1'b0;
    end

    // Back-to-back: issued in the DONE cycle of the 12-5 job; old result held meanwhile.
    issue(5, 6, 15, 1, 1);
    cmp("hold_D", int'(D), 7);
    cmp("hold_busy", int'(busy), 1);
    @(negedge clk);
    cmp("hold_D2", int'(D), 7);
    cmp("hold_mag", int'(mag), 7);
    idle(6);

    // Reset mid-operation: no done, outputs cleared immediately.
    wait_ready();
    start = 1'b1;
    A = 4'd9;
    B = 4'd3;
    @(posedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    cmp("abort_D", int'(D), 0);
    cmp("abort_Bo", int'(Bo), 0);
    cmp("abort_mag", int'(mag), 0);
    cmp("abort_ready", int'(ready), 1);
    cmp("abort_busy", int'(busy), 0);
    cmp("abort_done", int'(done), 0);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    cmp("abort_no_done_D", int'(D), 0);

    issue(10, 4, 6, 0, 6);
    idle(8);
    cmp("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor, the inverse operation of the team's 4-bit ripple-carry adder. Computes D = A - B LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow.
- Produces a borrow-out, a sign flag and a magnitude |A-B|, so the existing hex/7-segment path can display the difference.
- Sits between the switch/operand inputs and the display encoder. Uses a start/ready/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a subtraction; sampled only when ready=1.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- ready  output  1  high in IDLE and DONE; start is accepted only while ready=1.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse when a new result is published.
- D  output  WIDTH  registered A-B modulo 2^WIDTH.
- Bo  output  1  final borrow-out; 1 when A < B (unsigned).
- neg  output  1  equals Bo; sign flag for the display.
- mag  output  WIDTH  |A-B|: equals D when Bo=0, equals (~D)+1 mod 2^WIDTH when Bo=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, bit counter=0, borrow=0, shift registers=0.
  - D=0, Bo=0, neg=0, mag=0, done=0, busy=0, ready=1.
  - Reset asserted mid-operation aborts the operation: no done pulse, and the previous result is cleared to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - Edge with start=1: load A and B into shift registers, borrow<=0, cnt<=0, go to SHIFT.
  - Edge with start=0: stay in IDLE.
- SHIFT:
  - busy=1, ready=0.
  - Each edge computes one bit: d = a0 ^ b0 ^ borrow; borrow <= (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - d is shifted into the result register from the MSB side; both operand registers shift right; cnt increments.
  - start is ignored; a change on A or B has no effect.
- Completion:
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th SHIFT edge), the final bit is computed.
  - On that same edge D, Bo, neg and mag are all updated together.
  - done<=1 and state<=DONE on that edge.
  - While in SHIFT, the outputs keep the previous result.
- Latency: start accepted at edge t0; result and done become visible after edge t0+WIDTH; done is high for exactly that one cycle.
- DONE:
  - ready=1; results are held.
  - Next edge: done<=0.
  - If start=1 on that edge, the new operands are loaded and the block goes to SHIFT (back-to-back issue, no idle bubble).
  - If start=0, go to IDLE with results still held.
- Results stay stable until the next completion or reset.
- Arithmetic: D is always modulo 2^WIDTH. mag is computed combinationally from the final bits and stored in a register; it equals 2^(WIDTH-1) when A-B = -2^(WIDTH-1).

Test Plan:
- Simple difference: reset, then start with A=9, B=3 (WIDTH=4) -> done pulses exactly 4 edges after acceptance; D=6, Bo=0, neg=0, mag=6.
- Negative result: A=3, B=9 -> D=4'b1010, Bo=1, neg=1, mag=6.
- Boundary values: A=0, B=0 -> D=0, Bo=0, mag=0. A=0, B=15 -> D=1, Bo=1, mag=15. A=15, B=0 -> D=15, Bo=0, mag=15.
- Ignored start: start held high throughout SHIFT, and A/B changed to 7/7 mid-operation on a 12-5 job -> only one done pulse; D=7, Bo=0. The block returns to SHIFT only from the DONE cycle.
- Back-to-back issue: start high in the DONE cycle with A=5, B=6 -> second done occurs 4 edges later with D=15, Bo=1, mag=1. The first result (12-5=7) is held during the second operation.
- Reset mid-operation: rst_n pulled low asynchronously (mid-cycle) after 2 SHIFT edges -> outputs go to 0 immediately, ready=1, no done pulse. A fresh start after rst_n rises completes correctly.
